// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter for the MIPS Avalon-style memory bus.
// Grant is held for the whole of a stalled transfer; a sticky watchdog flags long stalls.
module mips_bus_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_address,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  output logic            m0_waitrequest,
  output logic [DW-1:0]   m0_readdata,
  input  logic [AW-1:0]   m1_address,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  output logic            m1_waitrequest,
  output logic [DW-1:0]   m1_readdata,
  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  input  logic            s_waitrequest,
  input  logic [DW-1:0]   s_readdata,
  output logic [1:0]      grant,
  output logic            timeout
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StGnt0 = 2'b01;
  localparam logic [1:0] StGnt1 = 2'b10;

  localparam int unsigned CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CW-1:0] CntMax = CW'(WAIT_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic req0, req1;
  logic own_req, other_req, stalled;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    case (state_q)
      StGnt0: begin
        own_req   = req0;
        other_req = req1;
      end
      StGnt1: begin
        own_req   = req1;
        other_req = req0;
      end
      default: ;
    endcase
  end

  assign stalled = own_req & s_waitrequest;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1)  state_d = last_q ? StGnt0 : StGnt1;
        else if (req0)     state_d = StGnt0;
        else if (req1)     state_d = StGnt1;
      end
      StGnt0, StGnt1: begin
        // Hand over on completion or abandonment only if the other side is waiting.
        if (!stalled && other_req) begin
          state_d = (state_q == StGnt0) ? StGnt1 : StGnt0;
          last_d  = (state_q == StGnt1);
        end else if (!own_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (stalled) begin
      if (cnt_q == CntMax) timeout_d = 1'b1;
      else                 cnt_d     = cnt_q + 1'b1;
      if (cnt_q == CntMax) cnt_d     = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = req0;
    m1_waitrequest = req1;
    case (state_q)
      StGnt0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      StGnt1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign grant       = state_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: vector table plus watchdog and async-reset sequences.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic [1:0]  grant;
  logic        timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.AW(32), .DW(32), .WAIT_TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .grant          (grant),
    .timeout        (timeout)
  );

  typedef struct {
    logic       rd0, wr0, rd1, wr1, sw;
    logic [1:0] g;
    logic       w0, w1, sr, swr;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [4:0] in, input logic [1:0] g, input logic [3:0] o);
    vec_t v;
    {v.rd0, v.wr0, v.rd1, v.wr1, v.sw} = in;
    v.g = g;
    {v.w0, v.w1, v.sr, v.swr} = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd0, wr0, rd1, wr1, sw);
    m0_read = rd0; m0_write = wr0; m1_read = rd1; m1_write = wr1; s_waitrequest = sw;
  endtask

  initial begin
    logic [31:0] exp_sa, exp_sd;
    logic [3:0]  exp_sbe;

    //                rd0 wr0 rd1 wr1 sw   grant   w0 w1 sr swr
    vecs[0]  = mk(5'b00000, 2'b00, 4'b0000);
    vecs[1]  = mk(5'b10000, 2'b00, 4'b1000);
    vecs[2]  = mk(5'b10000, 2'b01, 4'b0010);
    vecs[3]  = mk(5'b00000, 2'b01, 4'b0000);
    vecs[4]  = mk(5'b00000, 2'b00, 4'b0000);
    vecs[5]  = mk(5'b10100, 2'b00, 4'b1100);
    vecs[6]  = mk(5'b10100, 2'b01, 4'b0110);
    vecs[7]  = mk(5'b10100, 2'b10, 4'b1010);
    vecs[8]  = mk(5'b10100, 2'b01, 4'b0110);
    for (int i = 9; i <= 13; i++) vecs[i] = mk(5'b10011, 2'b10, 4'b1101);
    vecs[14] = mk(5'b10010, 2'b10, 4'b1001);
    vecs[15] = mk(5'b10000, 2'b01, 4'b0010);
    vecs[16] = mk(5'b00000, 2'b01, 4'b0000);
    vecs[17] = mk(5'b00000, 2'b00, 4'b0000);

    m0_address = 32'h0000_1000; m0_writedata = 32'h1111_1111; m0_byteenable = 4'hF;
    m1_address = 32'h0000_2000; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'h3;
    s_readdata = 32'h0;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_grant", grant, 2'b00);
    chk("reset_s_read", s_read, 1'b0);
    chk("reset_s_address", s_address, 32'h0);
    chk("reset_timeout", timeout, 1'b0);
    chk("reset_m0_wait", m0_waitrequest, 1'b1);
    chk("reset_m1_wait", m1_waitrequest, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rd0, vecs[i].wr0, vecs[i].rd1, vecs[i].wr1, vecs[i].sw);
      s_readdata = 32'hA5A5_0000 + 32'(i);
      #2;
      exp_sa  = (vecs[i].g == 2'b01) ? 32'h1000 : (vecs[i].g == 2'b10) ? 32'h2000 : 32'h0;
      exp_sd  = (vecs[i].g == 2'b01) ? 32'h1111_1111 :
                (vecs[i].g == 2'b10) ? 32'hDEAD_BEEF : 32'h0;
      exp_sbe = (vecs[i].g == 2'b01) ? 4'hF : (vecs[i].g == 2'b10) ? 4'h3 : 4'h0;
      chk($sformatf("v%0d_grant", i), grant, vecs[i].g);
      chk($sformatf("v%0d_m0_wait", i), m0_waitrequest, vecs[i].w0);
      chk($sformatf("v%0d_m1_wait", i), m1_waitrequest, vecs[i].w1);
      chk($sformatf("v%0d_s_read", i), s_read, vecs[i].sr);
      chk($sformatf("v%0d_s_write", i), s_write, vecs[i].swr);
      chk($sformatf("v%0d_s_address", i), s_address, exp_sa);
      chk($sformatf("v%0d_s_writedata", i), s_writedata, exp_sd);
      chk($sformatf("v%0d_s_byteenable", i), 32'(s_byteenable), 32'(exp_sbe));
      chk($sformatf("v%0d_m0_readdata", i), m0_readdata, 32'hA5A5_0000 + 32'(i));
      chk($sformatf("v%0d_m1_readdata", i), m1_readdata, 32'hA5A5_0000 + 32'(i));
      chk($sformatf("v%0d_timeout", i), timeout, 1'b0);
      @(posedge clk); #1;
    end

    // Watchdog: m0 read stuck behind a stalled slave.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("wd_idle_grant", grant, 2'b00);
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wd_stall%0d_timeout", k), timeout, 1'b0);
      chk($sformatf("wd_stall%0d_grant", k), grant, 2'b01);
      @(posedge clk); #1;
    end
    chk("wd_timeout_set", timeout, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("wd_timeout_sticky", timeout, 1'b1);
    chk("wd_idle_after", grant, 2'b00);
    reset = 1'b0;
    #1;
    chk("wd_reset_clears", timeout, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Async reset in the middle of a stalled m1 write.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("ar_grant_before", grant, 2'b10);
    chk("ar_s_write_before", s_write, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_s_write_now", s_write, 1'b0);
    chk("ar_grant_now", grant, 2'b00);
    chk("ar_m1_wait", m1_waitrequest, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ar_restart_grant", grant, 2'b01);
    chk("ar_restart_addr", s_address, 32'h1000);
    @(posedge clk); #1;
    chk("ar_alternate_grant", grant, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master arbiter for the single Avalon-style memory bus of the MIPS system: address, read, write, writedata, byteenable, waitrequest, readdata.
- Master 0 is the CPU bus port. Master 1 is a secondary requester, such as the test loader or a DMA.
- Arbitrates per transfer, round-robin, and holds the grant for the whole of any stalled transfer.
- Routes the granted master onto the slave bus. Includes a stall watchdog.

Parameters:
- AW, 32, address width
- DW, 32, data width; byteenable width is DW/8
- WAIT_TIMEOUT, 1024, consecutive stalled cycles of one transfer before timeout is flagged

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_address  in  AW  master 0 address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DW  master 0 write data
- m0_byteenable  in  DW/8  master 0 byte lanes
- m0_waitrequest  out  1  stall to master 0
- m0_readdata  out  DW  read data to master 0
- m1_*  same set as m0_*, for master 1
- s_address  out  AW  to slave
- s_read  out  1  to slave
- s_write  out  1  to slave
- s_writedata  out  DW  to slave
- s_byteenable  out  DW/8  to slave
- s_waitrequest  in  1  slave stall
- s_readdata  in  DW  slave read data
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle
- timeout  out  1  sticky watchdog flag

Behaviour:
- Definitions:
  - reqN = mN_read | mN_write. Masters never assert read and write together; the arbiter forwards both unchanged if they do.
  - A transfer completes in any cycle where the owner's req = 1 and s_waitrequest = 0.
- Reset (reset = 0, asynchronous):
  - state = IDLE, last = 1 (m0 wins the first tie), stall counter = 0, timeout = 0.
  - All s_* outputs = 0, grant = 00.
  - mN_waitrequest = reqN, combinational.
  - Takes effect immediately, including mid-transfer. The aborted transfer is not replayed.
- States: IDLE, GNT0, GNT1. The grant is registered, so arbitration costs one cycle from IDLE.
- IDLE transitions:
  - req0 & req1 → GNTx, where x != last.
  - Only reqN → GNTN.
  - No request → stay in IDLE.
- GNTx transitions, where y is the other master:
  - Completion cycle and reqy = 1 → GNTy next cycle; last = x. No bubble.
  - Completion cycle and reqy = 0 → stay in GNTx (park).
  - reqx = 0 and reqy = 1 → GNTy; last = x.
  - reqx = 0 and reqy = 0 → IDLE.
  - reqx = 1 and s_waitrequest = 1 → stay. The grant never changes mid-transfer.
- Output mux (combinational from state):
  - In GNTx, s_* = mx_* and mx_waitrequest = s_waitrequest.
  - The non-owner gets my_waitrequest = reqy, so a requesting non-owner is stalled and an idle one sees 0.
  - In IDLE, all s_* = 0 and both mN_waitrequest = reqN.
  - m0_readdata = m1_readdata = s_readdata, broadcast. Only the owner samples it.
- Watchdog:
  - The counter increments each cycle the owner has req = 1 and s_waitrequest = 1.
  - It clears on completion, on a state change, and in IDLE.
  - When the counter reaches WAIT_TIMEOUT−1 while still stalled, timeout sets on the next edge and stays set until reset.
  - The counter saturates at WAIT_TIMEOUT−1. Arbitration is unaffected.
- grant mirrors the state: IDLE = 00, GNT0 = 01, GNT1 = 10.

Test Plan:
- Reset release, then m0_read=1 at 0x0000_1000 with s_waitrequest=0 → cycle 1: grant=00, m0_waitrequest=1. Cycle 2: grant=01, s_address=0x1000, s_read=1, m0_waitrequest=0, m0_readdata=s_readdata.
- req0 and req1 both rise in the same IDLE cycle → m0 granted first (last=1 after reset). On m0's completion with req1 still high → grant=10 the next cycle, no idle gap. Repeating strictly alternates 01,10,01,10.
- m1 writes 0xDEADBEEF, byteenable=0011, and the slave holds s_waitrequest=1 for 5 cycles while m0 requests → grant stays 10 throughout and m0_waitrequest=1. s_writedata holds 0xDEADBEEF. Grant goes to 01 the cycle after waitrequest falls.
- m0 is parked in GNT0, then drops req0 with req1=0 → IDLE next cycle, all s_* = 0, grant=00.
- WAIT_TIMEOUT=8 and s_waitrequest stuck at 1 under an m0 read → timeout=1 after exactly 8 stalled cycles and stays 1 after waitrequest releases. Reset clears it.
- reset asserted low mid-stall in GNT1 → s_write=0 and grant=00 in the same cycle without waiting for a clock. After release, the first request restarts from IDLE with m0 priority.
